pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use dependences, taken-branch redirects, multi-cycle mult/div occupancy of EX, and data-memory wait states. It drives per-stage register write enables and bubble/flush controls, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_controller_pkg.sv | 47 ++++
 rtl/pipeline_hazard_controller_load_use_detector.sv | 25 ++
 rtl/pipeline_hazard_controller.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer and its load-use comparator.
// Holds the FSM encoding, the zero-register constant and the stage control bundle.
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } fsm_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic mem_wb_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic muldiv_done;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_DEFAULT = '{
      pc_write:     1'b1,
      if_id_write:  1'b1,
      id_ex_write:  1'b1,
      ex_mem_write: 1'b1,
      mem_wb_write: 1'b1,
      if_id_flush:  1'b0,
      id_ex_flush:  1'b0,
      ex_mem_flush: 1'b0,
      muldiv_done:  1'b0
   };

   // Front end frozen while EX is occupied by mult/div; a bubble drains into MEM.
   function automatic stage_ctrl_t ctrl_md_freeze();
      stage_ctrl_t c;
      c              = CTRL_DEFAULT;
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_write  = 1'b0;
      c.ex_mem_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
// Register 0 never creates a dependence since it is hardwired to zero.
module load_use_detector
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  mem_read,
   input  logic [REG_ADDR_W-1:0] load_rt,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic                  uses_rt,
   output logic                  lu_hazard
);

   logic dest_nonzero_s;
   logic rs_match_s;
   logic rt_match_s;

   assign dest_nonzero_s = (load_rt != REG_ADDR_W'(REG_ZERO));
   assign rs_match_s     = (load_rt == rs);
   assign rt_match_s     = uses_rt && (load_rt == rt);
   assign lu_hazard      = mem_read && dest_nonzero_s && (rs_match_s || rt_match_s);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, mult/div occupancy,
// taken-branch redirects and load-use bubbles, plus a saturating stall-cycle counter.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int REG_ADDR_W    = 5,
   parameter int PERF_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_stall,
   input  logic                  EX_branch_taken,
   input  logic                  ID_EX_memRead,
   input  logic                  ID_EX_muldiv,
   input  logic [REG_ADDR_W-1:0] ID_EX_rt,
   input  logic [REG_ADDR_W-1:0] IF_ID_rs,
   input  logic [REG_ADDR_W-1:0] IF_ID_rt,
   input  logic                  IF_ID_usesRt,
   output logic                  PC_write,
   output logic                  IF_ID_write,
   output logic                  ID_EX_write,
   output logic                  EX_MEM_write,
   output logic                  MEM_WB_write,
   output logic                  IF_ID_flush,
   output logic                  ID_EX_flush,
   output logic                  EX_MEM_flush,
   output logic                  muldiv_busy,
   output logic                  muldiv_done,
   output logic [PERF_W-1:0]     stall_cycles
);

   fsm_t              fsm_r;
   fsm_t              fsm_nxt_s;
   logic [7:0]        cnt_r;
   logic [7:0]        cnt_nxt_s;
   logic [PERF_W-1:0] stall_cycles_r;
   logic              lu_hazard_s;
   stage_ctrl_t       ctrl_s;

   load_use_detector #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use (
      .mem_read  (ID_EX_memRead),
      .load_rt   (ID_EX_rt),
      .rs        (IF_ID_rs),
      .rt        (IF_ID_rt),
      .uses_rt   (IF_ID_usesRt),
      .lu_hazard (lu_hazard_s)
   );

   // Hazard arbitration: mem_stall, then mult/div, then branch, then load-use.
   always_comb begin
      ctrl_s    = CTRL_DEFAULT;
      fsm_nxt_s = fsm_r;
      cnt_nxt_s = cnt_r;
      if (reset) begin
         fsm_nxt_s = RUN;
         cnt_nxt_s = 8'd0;
      end else if (mem_stall) begin
         ctrl_s.pc_write     = 1'b0;
         ctrl_s.if_id_write  = 1'b0;
         ctrl_s.id_ex_write  = 1'b0;
         ctrl_s.ex_mem_write = 1'b0;
         ctrl_s.mem_wb_write = 1'b0;
      end else if (fsm_r == MD_BUSY) begin
         // Branch and load-use inputs are meaningless here: EX holds the mult/div.
         if (cnt_r != 8'd0) begin
            ctrl_s    = ctrl_md_freeze();
            cnt_nxt_s = cnt_r - 8'd1;
         end else begin
            ctrl_s.muldiv_done = 1'b1;
            fsm_nxt_s          = RUN;
         end
      end else if (ID_EX_muldiv) begin
         ctrl_s    = ctrl_md_freeze();
         cnt_nxt_s = 8'(MULDIV_CYCLES - 2);
         fsm_nxt_s = MD_BUSY;
      end else if (EX_branch_taken) begin
         ctrl_s.if_id_flush = 1'b1;
         ctrl_s.id_ex_flush = 1'b1;
      end else if (lu_hazard_s) begin
         ctrl_s.pc_write    = 1'b0;
         ctrl_s.if_id_write = 1'b0;
         ctrl_s.id_ex_flush = 1'b1;
      end else begin
         ctrl_s = CTRL_DEFAULT;
      end
   end

   // State, countdown and saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_r          <= RUN;
         cnt_r          <= 8'd0;
         stall_cycles_r <= {PERF_W{1'b0}};
      end else begin
         fsm_r <= fsm_nxt_s;
         cnt_r <= cnt_nxt_s;
         if (!ctrl_s.pc_write && (stall_cycles_r != {PERF_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + PERF_W'(1);
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
      end
   end

   assign PC_write     = ctrl_s.pc_write;
   assign IF_ID_write  = ctrl_s.if_id_write;
   assign ID_EX_write  = ctrl_s.id_ex_write;
   assign EX_MEM_write = ctrl_s.ex_mem_write;
   assign MEM_WB_write = ctrl_s.mem_wb_write;
   assign IF_ID_flush  = ctrl_s.if_id_flush;
   assign ID_EX_flush  = ctrl_s.id_ex_flush;
   assign EX_MEM_flush = ctrl_s.ex_mem_flush;
   assign muldiv_done  = ctrl_s.muldiv_done;
   assign muldiv_busy  = (fsm_r == MD_BUSY);
   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (MULDIV_CYCLES=4, PERF_W=4).
// Each scenario pushes expected output vectors to a scoreboard and compares at the falling edge.
module tb_pipeline_hazard_controller;

   localparam int PERF_W = 4;

   // Expected control byte: {PC,IF_ID,ID_EX,EX_MEM,MEM_WB write, IF_ID,ID_EX,EX_MEM flush}
   localparam logic [7:0] EN_ALL = 8'b11111_000;
   localparam logic [7:0] FRZ    = 8'b00011_001;
   localparam logic [7:0] ALL0   = 8'b00000_000;
   localparam logic [7:0] LU     = 8'b00111_010;
   localparam logic [7:0] BR     = 8'b11111_110;

   typedef struct {
      logic        rst;
      logic        ms;
      logic        br;
      logic        mr;
      logic        md;
      logic        ur;
      logic [4:0]  ldrt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [13:0] exp;
   } stim_t;

   logic clk = 1'b0;
   logic reset, mem_stall, EX_branch_taken, ID_EX_memRead, ID_EX_muldiv, IF_ID_usesRt;
   logic [4:0] ID_EX_rt, IF_ID_rs, IF_ID_rt;
   logic PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
   logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, muldiv_busy, muldiv_done;
   logic [PERF_W-1:0] stall_cycles;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [13:0] sb[$];

   always #5 clk = ~clk;

   pipeline_hazard_controller #(
      .MULDIV_CYCLES (4),
      .REG_ADDR_W    (5),
      .PERF_W        (PERF_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_stall       (mem_stall),
      .EX_branch_taken (EX_branch_taken),
      .ID_EX_memRead   (ID_EX_memRead),
      .ID_EX_muldiv    (ID_EX_muldiv),
      .ID_EX_rt        (ID_EX_rt),
      .IF_ID_rs        (IF_ID_rs),
      .IF_ID_rt        (IF_ID_rt),
      .IF_ID_usesRt    (IF_ID_usesRt),
      .PC_write        (PC_write),
      .IF_ID_write     (IF_ID_write),
      .ID_EX_write     (ID_EX_write),
      .EX_MEM_write    (EX_MEM_write),
      .MEM_WB_write    (MEM_WB_write),
      .IF_ID_flush     (IF_ID_flush),
      .ID_EX_flush     (ID_EX_flush),
      .EX_MEM_flush    (EX_MEM_flush),
      .muldiv_busy     (muldiv_busy),
      .muldiv_done     (muldiv_done),
      .stall_cycles    (stall_cycles)
   );

   function automatic logic [13:0] ex(logic [7:0] c, logic busy, logic done, logic [3:0] st);
      return {c, busy, done, st};
   endfunction

   function automatic stim_t mk(logic rst, logic ms, logic br, logic mr, logic md, logic ur,
                                logic [4:0] ldrt, logic [4:0] rs, logic [4:0] rt, logic [13:0] e);
      stim_t s;
      s.rst = rst; s.ms = ms; s.br = br; s.mr = mr; s.md = md; s.ur = ur;
      s.ldrt = ldrt; s.rs = rs; s.rt = rt; s.exp = e;
      return s;
   endfunction

   function automatic logic [13:0] observe();
      return {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
              IF_ID_flush, ID_EX_flush, EX_MEM_flush, muldiv_busy, muldiv_done, stall_cycles};
   endfunction

   // Apply one cycle of inputs shortly after the rising edge and queue its expectation.
   task automatic drive(input stim_t s);
      @(posedge clk);
      #2;
      reset = s.rst; mem_stall = s.ms; EX_branch_taken = s.br; ID_EX_memRead = s.mr;
      ID_EX_muldiv = s.md; IF_ID_usesRt = s.ur; ID_EX_rt = s.ldrt; IF_ID_rs = s.rs; IF_ID_rt = s.rt;
      sb.push_back(s.exp);
   endtask

   task automatic do_reset();
      drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 14'd0));
      void'(sb.pop_back());
   endtask

   task automatic test_reset();
      stim_t t[$];
      logic [13:0] got, e;
      do_reset();
      t.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, ex(EN_ALL, 1'b0, 1'b0, 4'd0)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd0)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL reset[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_load_use();
      stim_t t[$];
      logic [13:0] got, e;
      do_reset();
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd9, ex(LU,     1'b0, 1'b0, 4'd0)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd9, ex(EN_ALL, 1'b0, 1'b0, 4'd1)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd1)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd1)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_rt_gating();
      stim_t t[$];
      logic [13:0] got, e;
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd2, 5'd5, ex(EN_ALL, 1'b0, 1'b0, 4'd1)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd2, 5'd5, ex(LU,     1'b0, 1'b0, 4'd1)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, ex(EN_ALL, 1'b0, 1'b0, 4'd2)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, ex(EN_ALL, 1'b0, 1'b0, 4'd2)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL rt_gating[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_muldiv();
      stim_t t[$];
      logic [13:0] got, e;
      do_reset();
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(FRZ,    1'b0, 1'b0, 4'd0)));
      t.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 5'd4, 5'd0, ex(FRZ,    1'b1, 1'b0, 4'd1)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(FRZ,    1'b1, 1'b0, 4'd2)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b1, 1'b1, 4'd3)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd3)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL muldiv[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_branch();
      stim_t t[$];
      logic [13:0] got, e;
      t.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0, ex(BR,     1'b0, 1'b0, 4'd3)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd3)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL branch[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_mem_stall();
      stim_t t[$];
      logic [13:0] got, e;
      do_reset();
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 5'd0, ex(FRZ,    1'b0, 1'b0, 4'd0)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(FRZ,    1'b1, 1'b0, 4'd1)));
      t.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(ALL0,   1'b1, 1'b0, 4'd2)));
      t.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(ALL0,   1'b1, 1'b0, 4'd3)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(FRZ,    1'b1, 1'b0, 4'd4)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b1, 1'b1, 4'd5)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd5)));
      t.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(ALL0,   1'b0, 1'b0, 4'd5)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd6)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL mem_stall[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_reset_mid_md();
      stim_t t[$];
      logic [13:0] got, e;
      do_reset();
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ex(FRZ,    1'b0, 1'b0, 4'd0)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(FRZ,    1'b1, 1'b0, 4'd1)));
      t.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b1, 1'b0, 4'd2)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd0)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd0)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL reset_mid_md[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   task automatic test_saturation();
      stim_t t[$];
      logic [13:0] got, e;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         t.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                        ex(ALL0, 1'b0, 1'b0, (k < 15) ? 4'(k) : 4'd15)));
      end
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd15)));
      t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ex(EN_ALL, 1'b0, 1'b0, 4'd15)));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         got = observe(); e = sb.pop_front(); n_cmp++;
         if (got !== e) begin n_fail++; $display("FAIL saturation[%0d] got=%b exp=%b", i, got, e); end
      end
   endtask

   initial begin
      reset = 1'b1; mem_stall = 1'b0; EX_branch_taken = 1'b0; ID_EX_memRead = 1'b0;
      ID_EX_muldiv = 1'b0; IF_ID_usesRt = 1'b0; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
      test_reset();
      test_load_use();
      test_rt_gating();
      test_muldiv();
      test_branch();
      test_mem_stall();
      test_reset_mid_md();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
